// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_pkg
//  Purpose  : Shared I2C definitions: controller states, bit-slot phases and
//             the R/W bit encoding. Used by both master and slave sides.
//  Revision : 1.0  initial release
// ============================================================================
package i2c_pkg;

    // Controller states for one single-byte write transaction
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_ACK_A = 3'd3,
        ST_DATA  = 3'd4,
        ST_ACK_D = 3'd5,
        ST_STOP  = 3'd6
    } i2c_state_t;

    // Quarter phases inside every bit slot
    localparam logic [1:0] Q0 = 2'd0;   // SCL low, SDA updated
    localparam logic [1:0] Q1 = 2'd1;   // SCL released
    localparam logic [1:0] Q2 = 2'd2;   // SCL high, SDA sampled
    localparam logic [1:0] Q3 = 2'd3;   // SCL low

    // R/W bit appended to the 7-bit address
    localparam logic I2C_WRITE = 1'b0;

    // Depth of the SDA/SCL input synchronisers
    localparam int SYNC_STAGES = 2;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_qtick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_qtick_gen
//  Purpose  : SCL quarter-period tick generator. Counts 0..CLK_DIV-1 while
//             running and pulses qtick at terminal count. A hold request
//             (clock stretching) freezes the count once it has passed the
//             input-synchroniser latency window.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_qtick_gen #(
    parameter int CLK_DIV   = 250,
    parameter int HOLD_FROM = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    input  logic hold,
    output logic qtick
);

    localparam int CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TERM_I  = CLK_DIV - 1;
    // Hold is ignored during the first cycles of a quarter: the released SCL
    // has not yet propagated through the synchroniser, so a low read there
    // is not a stretch.
    localparam int HOLD_I  = (HOLD_FROM < TERM_I) ? HOLD_FROM : TERM_I;
    localparam logic [CW-1:0] TERM    = CW'(TERM_I);
    localparam logic [CW-1:0] HOLD_AT = CW'(HOLD_I);

    logic [CW-1:0] r_cnt;
    logic          w_frozen;

    assign w_frozen = hold && (r_cnt >= HOLD_AT);
    assign qtick    = run && !w_frozen && (r_cnt == TERM);

    // Quarter counter: cleared when idle, frozen while stretched, wraps at TERM
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (!run) begin
            r_cnt <= '0;
        end else if (w_frozen) begin
            r_cnt <= r_cnt;
        end else if (r_cnt == TERM) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule : i2c_qtick_gen
`default_nettype wire

// File: rtl/i2c_master_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_master_writer
//  Purpose  : Single-byte I2C write master. On start it sends START,
//             address+W, checks ACK, sends one data byte, checks ACK and
//             issues STOP, then pulses done. Open-drain SDA/SCL, honours
//             slave clock stretching, reports NACK on ack_err.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_master_writer
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        i2c_sda,
    inout  wire        i2c_scl
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    i2c_state_t r_state;
    logic [1:0] r_phase;
    logic [2:0] r_bitcnt;
    logic [7:0] r_sh;
    logic [7:0] r_dbuf;
    logic       r_ack_err;
    logic       r_done;
    logic       r_sda_low;
    logic       r_scl_low;
    logic       r_sda_s1;
    logic       r_sda_s2;
    logic       r_scl_s1;
    logic       r_scl_s2;

    // ------------------------------------------------------------------
    // Combinational next-state values
    // ------------------------------------------------------------------
    i2c_state_t w_state_nxt;
    logic [1:0] w_phase_nxt;
    logic [2:0] w_bitcnt_nxt;
    logic [7:0] w_sh_nxt;
    logic [7:0] w_dbuf_nxt;
    logic       w_ack_err_nxt;
    logic       w_done_nxt;
    logic [1:0] w_drive_nxt;
    logic       w_qtick;
    logic       w_hold;
    logic       w_slot_end;
    logic       w_ack_sample;

    // Open-drain pads: only ever pull low or float
    assign i2c_sda = r_sda_low ? 1'b0 : 1'bz;
    assign i2c_scl = r_scl_low ? 1'b0 : 1'bz;

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign ack_err = r_ack_err;

    // Stretch: SCL was released in Q1 but a slave still holds it low
    assign w_hold       = (r_state != ST_IDLE) && (r_phase == Q1) && !r_scl_s2;
    assign w_slot_end   = w_qtick && (r_phase == Q3);
    assign w_ack_sample = w_qtick && (r_phase == Q2);

    i2c_qtick_gen #(
        .CLK_DIV   (CLK_DIV),
        .HOLD_FROM (SYNC_STAGES)
    ) u_qtick (
        .CLK   (CLK),
        .RST   (RST),
        .run   (r_state != ST_IDLE),
        .hold  (w_hold),
        .qtick (w_qtick)
    );

    // Pad pull-down pattern for a given state/phase; {sda_low, scl_low}
    function automatic logic [1:0] od_drive(input i2c_state_t st,
                                            input logic [1:0] ph,
                                            input logic       msb);
        logic sda_low;
        logic scl_low;
        sda_low = 1'b0;
        scl_low = 1'b0;
        case (st)
            ST_START: begin
                // SDA falls in Q2 while SCL is still high, SCL falls in Q3
                sda_low = (ph == Q2) || (ph == Q3);
                scl_low = (ph == Q3);
            end
            ST_ADDR, ST_DATA: begin
                sda_low = !msb;
                scl_low = (ph == Q0) || (ph == Q3);
            end
            ST_ACK_A, ST_ACK_D: begin
                sda_low = 1'b0;
                scl_low = (ph == Q0) || (ph == Q3);
            end
            ST_STOP: begin
                // SDA held low through SCL rise, released last with SCL high
                sda_low = (ph != Q3);
                scl_low = (ph == Q0);
            end
            default: begin
                sda_low = 1'b0;
                scl_low = 1'b0;
            end
        endcase
        return {sda_low, scl_low};
    endfunction

    // Two-flop synchronisers on the bus inputs; idle bus reads high
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
        end else begin
            r_sda_s1 <= i2c_sda;
            r_sda_s2 <= r_sda_s1;
            r_scl_s1 <= i2c_scl;
            r_scl_s2 <= r_scl_s1;
        end
    end

    // Next-state, shift register, ACK capture and pad pattern
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_bitcnt_nxt  = r_bitcnt;
        w_sh_nxt      = r_sh;
        w_dbuf_nxt    = r_dbuf;
        w_ack_err_nxt = r_ack_err;
        w_done_nxt    = 1'b0;

        if (w_qtick) begin
            w_phase_nxt = r_phase + 2'd1;
        end

        case (r_state)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped
                if (start && !r_done) begin
                    w_sh_nxt      = {addr, I2C_WRITE};
                    w_dbuf_nxt    = data_in;
                    w_ack_err_nxt = 1'b0;
                    w_phase_nxt   = Q0;
                    w_state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (w_slot_end) begin
                    w_bitcnt_nxt = 3'd7;
                    w_state_nxt  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (w_slot_end) begin
                    if (r_bitcnt == 3'd0) begin
                        w_sh_nxt    = r_dbuf;
                        w_state_nxt = ST_ACK_A;
                    end else begin
                        w_sh_nxt     = {r_sh[6:0], 1'b0};
                        w_bitcnt_nxt = r_bitcnt - 3'd1;
                    end
                end
            end
            ST_ACK_A: begin
                if (w_ack_sample && r_sda_s2) begin
                    w_ack_err_nxt = 1'b1;
                end
                if (w_slot_end) begin
                    // Address NACK skips the data byte entirely
                    if (r_ack_err) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bitcnt_nxt = 3'd7;
                        w_state_nxt  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_slot_end) begin
                    w_sh_nxt = {r_sh[6:0], 1'b0};
                    if (r_bitcnt == 3'd0) begin
                        w_state_nxt = ST_ACK_D;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt - 3'd1;
                    end
                end
            end
            ST_ACK_D: begin
                if (w_ack_sample && r_sda_s2) begin
                    w_ack_err_nxt = 1'b1;
                end
                if (w_slot_end) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_slot_end) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = Q0;
            end
        endcase

        // Pads are registered from the next state so they switch cleanly
        w_drive_nxt = od_drive(w_state_nxt, w_phase_nxt, w_sh_nxt[7]);
    end

    // State register; reset aborts immediately with both pads floating
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_phase   <= Q0;
            r_bitcnt  <= 3'd0;
            r_sh      <= 8'd0;
            r_dbuf    <= 8'd0;
            r_ack_err <= 1'b0;
            r_done    <= 1'b0;
            r_sda_low <= 1'b0;
            r_scl_low <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_sh      <= w_sh_nxt;
            r_dbuf    <= w_dbuf_nxt;
            r_ack_err <= w_ack_err_nxt;
            r_done    <= w_done_nxt;
            r_sda_low <= w_drive_nxt[1];
            r_scl_low <= w_drive_nxt[0];
        end
    end

endmodule : i2c_master_writer
`default_nettype wire

// File: tb/tb_i2c_master_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_master_writer
//  Purpose  : Self-checking bench for i2c_master_writer. A bus-level slave
//             model decodes START/STOP and bytes from the pins and ACKs per
//             a per-byte policy; expectations come from transaction rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_master_writer;

    localparam int CLK_DIV = 4;
    // Data bit-3 slot is quarters 56..59; its Q1 (SCL release) is quarter 57
    localparam int STR_ON  = 56 * CLK_DIV + 2;
    localparam int STR_REL = 57 * CLK_DIV;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       start = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] data_in = 8'd0;
    logic       busy;
    logic       done;
    logic       ack_err;
    wire        sda;
    wire        scl;

    logic slv_sda_low = 1'b0;
    logic slv_scl_low = 1'b0;

    assign sda = slv_sda_low ? 1'b0 : 1'bz;
    assign scl = slv_scl_low ? 1'b0 : 1'bz;
    pullup (sda);
    pullup (scl);

    int total = 0;
    int bad   = 0;

    i2c_master_writer #(.CLK_DIV(CLK_DIV)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .addr    (addr),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .i2c_sda (sda),
        .i2c_scl (scl)
    );

    always #5 CLK = ~CLK;

    // ---------------- bus-level slave / monitor ----------------
    logic       prev_sda = 1'b1;
    logic       prev_scl = 1'b1;
    bit         in_frame = 1'b0;
    int         nbits = 0;
    int         byte_idx = 0;
    logic [7:0] shr = 8'd0;
    logic [7:0] rx_q[$];
    int         clk_total = 0;
    int         start_total = 0;
    int         stop_total = 0;
    int         done_total = 0;
    bit         ack_pol[2];

    always @(negedge CLK) begin
        if (done) done_total++;
        if (scl && prev_scl && prev_sda && !sda) begin
            start_total++;
            in_frame = 1'b1;
            nbits    = 0;
            byte_idx = 0;
        end else if (scl && prev_scl && !prev_sda && sda) begin
            if (in_frame) begin
                stop_total++;
                clk_total -= nbits;   // SCL rise preceding STOP is not a bit
            end
            in_frame    = 1'b0;
            nbits       = 0;
            slv_sda_low = 1'b0;
        end else if (in_frame && !prev_scl && scl) begin
            clk_total++;
            if (nbits < 8) begin
                shr = {shr[6:0], sda};
                nbits++;
                if (nbits == 8) rx_q.push_back(shr);
            end else begin
                nbits = 0;
            end
        end else if (in_frame && prev_scl && !scl) begin
            if (nbits == 8) begin
                slv_sda_low = (byte_idx < 2) ? ack_pol[byte_idx] : 1'b0;
                byte_idx++;
            end else begin
                slv_sda_low = 1'b0;
            end
        end
        prev_sda = sda;
        prev_scl = scl;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One transaction plus its reference expectations
    task automatic run_txn(input string name, input logic [6:0] a, input logic [7:0] d,
                           input bit ack_a, input bit ack_d, input int stretch_len,
                           input bit restart_glitch);
        int         rx_base, clk_base, done_base, st_base, sp_base;
        int         exp_q, exp_cyc, exp_clks, exp_nbytes, done_k, lim;
        bit         seen;
        logic       exp_err, busy_at_done, err_at_done;
        logic [7:0] exp_bytes[2];
        logic [7:0] got;

        exp_nbytes   = ack_a ? 2 : 1;
        exp_q        = ack_a ? 80 : 44;
        exp_err      = !ack_a || !ack_d;
        exp_clks     = ack_a ? 18 : 9;
        exp_cyc      = exp_q * CLK_DIV + 1 + stretch_len;
        exp_bytes[0] = {a, 1'b0};
        exp_bytes[1] = d;
        ack_pol[0]   = ack_a;
        ack_pol[1]   = ack_d;

        rx_base   = rx_q.size();
        clk_base  = clk_total;
        done_base = done_total;
        st_base   = start_total;
        sp_base   = stop_total;

        @(negedge CLK);
        addr    = a;
        data_in = d;
        start   = 1'b1;
        @(posedge CLK);              // sampling edge: cycle 1 follows it
        @(negedge CLK);
        start = 1'b0;
        chk({name, ":busy_after_start"}, busy, 1);

        seen = 1'b0;
        done_k = 0;
        busy_at_done = 1'b1;
        err_at_done = 1'bx;
        lim = exp_q * CLK_DIV + stretch_len + 200;
        for (int k = 1; k <= lim && !seen; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (stretch_len > 0 && k == STR_ON) slv_scl_low = 1'b1;
            if (stretch_len > 0 && k == STR_REL + stretch_len) slv_scl_low = 1'b0;
            if (restart_glitch && k == 10 * CLK_DIV) begin
                start   = 1'b1;
                data_in = 8'hFF;
            end
            if (restart_glitch && k == 10 * CLK_DIV + 1) begin
                start   = 1'b0;
                data_in = d;
            end
            if (done) begin
                seen         = 1'b1;
                done_k       = k;
                busy_at_done = busy;
                err_at_done  = ack_err;
            end
        end
        slv_scl_low = 1'b0;
        start       = 1'b0;

        chk({name, ":done_seen"}, seen, 1);
        chk({name, ":done_cycle"}, done_k + 1, exp_cyc);
        chk({name, ":busy_at_done"}, busy_at_done, 0);
        chk({name, ":ack_err_at_done"}, err_at_done, exp_err);

        repeat (12 * CLK_DIV) @(negedge CLK);
        chk({name, ":ack_err_held"}, ack_err, exp_err);
        chk({name, ":done_pulses"}, done_total - done_base, 1);
        chk({name, ":rx_count"}, rx_q.size() - rx_base, exp_nbytes);
        for (int i = 0; i < exp_nbytes; i++) begin
            got = (rx_q.size() > rx_base + i) ? rx_q[rx_base + i] : 8'h5A ^ exp_bytes[i];
            chk({name, ":rx_byte"}, got, exp_bytes[i]);
        end
        chk({name, ":scl_clocks"}, clk_total - clk_base, exp_clks);
        chk({name, ":starts"}, start_total - st_base, 1);
        chk({name, ":stops"}, stop_total - sp_base, 1);
    endtask

    // Abort a transfer with reset in the middle of the data byte
    task automatic reset_abort(input logic [6:0] a, input logic [7:0] d);
        ack_pol[0] = 1'b1;
        ack_pol[1] = 1'b1;
        @(negedge CLK);
        addr    = a;
        data_in = d;
        start   = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (200) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("abort:sda_released", sda, 1);
        chk("abort:scl_released", scl, 1);
        chk("abort:busy", busy, 0);
        chk("abort:done", done, 0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (4 * CLK_DIV) @(negedge CLK);
    endtask

    initial begin
        logic [6:0] ra;
        logic [7:0] rd;
        bit         rack_a, rack_d;

        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset:busy", busy, 0);
        chk("reset:done", done, 0);
        chk("reset:ack_err", ack_err, 0);
        chk("reset:sda", sda, 1);
        chk("reset:scl", scl, 1);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        run_txn("basic",     7'h3C, 8'hA5, 1'b1, 1'b1, 0,  1'b0);
        run_txn("addr_nack", 7'h3C, 8'hA5, 1'b0, 1'b0, 0,  1'b0);
        run_txn("data_nack", 7'h3C, 8'hA5, 1'b1, 1'b0, 0,  1'b0);
        run_txn("stretch",   7'h3C, 8'hA5, 1'b1, 1'b1, 20, 1'b0);
        run_txn("ign_start", 7'h3C, 8'hA5, 1'b1, 1'b1, 0,  1'b1);
        reset_abort(7'h3C, 8'hA5);
        run_txn("post_abort", 7'h3C, 8'hA5, 1'b1, 1'b1, 0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            ra     = 7'($urandom_range(0, 127));
            rd     = 8'($urandom_range(0, 255));
            rack_a = ($urandom_range(0, 3) != 0);
            rack_d = ($urandom_range(0, 1) != 0);
            run_txn("random", ra, rd, rack_a, rack_d, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_i2c_master_writer
`default_nettype wire
